icache_way_sched: RTL and testbench
===================================

# icache_way_sched

Scheduler that shares the instruction-cache way SRAMs between fetch lookups, refill writes and a whole-cache flush sweep. It sits between the icache control logic and the `NUM_WAYS` way SRAM instances. A lookup reads all ways in parallel; a refill writes one way; a flush writes zeros to every set of every way. The SRAMs have a 1-cycle registered read, and this block owns their req/we/addr/data pins.

## Interface
Parameters:
- NUM_WAYS, 4, number of way SRAMs
- ADDR_WIDTH, 8, set index width (depth 256)
- SET_WIDTH, 128, bits per set per way
- MAX_WR_BURST, 4, consecutive write grants allowed over a waiting read

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- flush_i  in  1  pulse: start flush sweep
- flush_busy_o  out  1  sweep in progress
- rd_valid_i  in  1  lookup request
- rd_ready_o  out  1  lookup accepted this cycle
- rd_addr_i  in  ADDR_WIDTH  lookup set index
- rd_rvalid_o  out  1  lookup data valid
- rd_data_o  out  NUM_WAYS*SET_WIDTH  all ways' data; way k at bits [k*SET_WIDTH +: SET_WIDTH]
- wr_valid_i  in  1  refill write request
- wr_ready_o  out  1  write accepted this cycle
- wr_addr_i  in  ADDR_WIDTH  write set index
- wr_way_i  in  clog2(NUM_WAYS)  target way
- wr_data_i  in  SET_WIDTH  write data
- way_req_o  out  NUM_WAYS  per-way SRAM request
- way_we_o  out  NUM_WAYS  per-way write enable
- way_addr_o  out  ADDR_WIDTH  shared SRAM address
- way_data_o  out  SET_WIDTH  shared SRAM write data
- way_rdata_i  in  NUM_WAYS*SET_WIDTH  SRAM read data, same packing as rd_data_o

## Operation
- FSM states:
  - IDLE: serves lookups and writes. `flush_i` moves to FLUSH.
  - FLUSH: sweeps a set counter from 0 to 2^ADDR_WIDTH-1. On the last set it returns to IDLE.
- Acceptance is combinational, and the SRAM is driven in the handshake cycle.
  - A write grant drives `way_req_o` and `way_we_o` one-hot on `wr_way_i`, with `way_addr_o`=`wr_addr_i` and `way_data_o`=`wr_data_i`.
  - A read grant drives `way_req_o` all ones, `way_we_o`=0 and `way_addr_o`=`rd_addr_i`.
  - With no grant, `way_req_o`=0 and `way_we_o`=0. `way_addr_o` and `way_data_o` are don't-care.
- Priority in IDLE: `flush_i` > write > read, subject to the starvation guard.
  - When `flush_i`=1, both readies are 0 in that cycle.
- Starvation guard: `starve_cnt` (0..MAX_WR_BURST) increments each cycle a write is granted while `rd_valid_i`=1.
  - When `starve_cnt`=MAX_WR_BURST and both requesters are valid, the read is granted, `wr_ready_o`=0, and the counter clears.
  - The counter also clears on any read grant and on any cycle in IDLE with `rd_valid_i`=0.
- FLUSH, every cycle:
  - `way_req_o`=all ones, `way_we_o`=all ones, `way_addr_o`=counter, `way_data_o`=0.
  - `rd_ready_o`=0, `wr_ready_o`=0, `flush_busy_o`=1.
  - `flush_i` is ignored (no restart).
  - The FLUSH→IDLE transition clears the counter and `starve_cnt`.
- Read response: `rd_rvalid_o` is registered, =1 exactly one cycle after a read grant. `rd_data_o` passes `way_rdata_i` through. There is no response backpressure.
- Ordering:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
  - A read and a write offered in the same cycle are never both granted.
- Requesters hold valid and payload stable until ready. The block does not check this.

## Timing
- Reset (`rst_i`=1 at an edge):
  - State becomes IDLE; counter, `starve_cnt` and `rd_valid` pipe are cleared.
  - `rd_rvalid_o`=0, `flush_busy_o`=0.
  - While `rst_i`=1, `rd_ready_o`, `wr_ready_o`, `way_req_o` and `way_we_o` are forced to 0.
  - Reset mid-flush aborts the sweep. Sets not yet cleared keep their contents.
  - A read granted in the cycle before reset gets no `rd_rvalid_o`.
- Lookup latency: grant at edge N, data valid during cycle N+1.
- Write latency: the write is committed at the grant edge.
- Flush:
  - `flush_i` sampled at edge N gives `flush_busy_o`=1 in cycles N+1 .. N+2^ADDR_WIDTH, writing sets 0..2^ADDR_WIDTH-1 in order.
  - IDLE and requests are accepted again from cycle N+2^ADDR_WIDTH+1 (cycle N+257 at default width).
- Throughput: one grant per cycle in IDLE. Back-to-back reads give `rd_rvalid_o` high continuously.

## Test plan
- Write way 2, addr 0x10, data 0xA5..A5. Read addr 0x10 next cycle. → `rd_rvalid_o` 1 cycle later; way 2 slice = 0xA5..A5; other ways unchanged.
- `rd_valid_i` and `wr_valid_i` held high continuously for 12 cycles. → Grant pattern W,W,W,W,R repeating. A read is granted in cycles 5 and 10. No two grants occur in the same cycle.
- Preload sets 0 and 255 in all ways. Pulse `flush_i`. → `flush_busy_o` high for exactly 256 cycles. Readies stay 0 throughout, including a mid-sweep `flush_i` pulse that must not restart the sweep. Reads of sets 0 and 255 afterwards return 0 in every way.
- `flush_i` in the same cycle as `rd_valid_i` and `wr_valid_i`. → Neither is granted. After the sweep, the write is granted before the read.
- `rst_i` asserted at sweep cycle 100. → Next cycle: `flush_busy_o`=0, all readies=0, `way_req_o`=0. After release, IDLE accepts a read immediately. Set 200 still holds its preloaded value.
- 8 back-to-back reads at addr 0..7. → `rd_rvalid_o` high for 8 consecutive cycles starting one cycle after the first grant. Data is in address order.

Source files
------------

// File: rtl/icache_way_sched.sv
// icache_way_sched: arbitrates the instruction-cache way SRAMs between fetch
// lookups (read all ways), refill writes (one way) and a whole-cache flush
// sweep that zeroes every set of every way.
module icache_way_sched #(
  parameter int NUM_WAYS     = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int SET_WIDTH    = 128,
  parameter int MAX_WR_BURST = 4,
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int SC_W  = $clog2(MAX_WR_BURST + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          flush_busy_o,
  input  logic                          rd_valid_i,
  output logic                          rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic                          rd_rvalid_o,
  output logic [NUM_WAYS*SET_WIDTH-1:0] rd_data_o,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [WAY_W-1:0]              wr_way_i,
  input  logic [SET_WIDTH-1:0]          wr_data_i,
  output logic [NUM_WAYS-1:0]           way_req_o,
  output logic [NUM_WAYS-1:0]           way_we_o,
  output logic [ADDR_WIDTH-1:0]         way_addr_o,
  output logic [SET_WIDTH-1:0]          way_data_o,
  input  logic [NUM_WAYS*SET_WIDTH-1:0] way_rdata_i
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [SC_W-1:0]       r_starve;
  logic                  r_rd_vld_p1;

  logic                  w_idle;
  logic                  w_flushing;
  logic                  w_force_rd;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic [NUM_WAYS-1:0]   w_onehot;

  // Grant decision: flush beats write beats read, except that a read that has
  // watched MAX_WR_BURST writes go by takes the slot. Reset masks all grants.
  always_comb begin
    w_idle     = (r_state == S_IDLE) && !rst_i;
    w_flushing = (r_state == S_FLUSH) && !rst_i;
    w_force_rd = rd_valid_i && wr_valid_i && (r_starve == SC_W'(MAX_WR_BURST));
    w_wr_gnt   = w_idle && !flush_i && wr_valid_i && !w_force_rd;
    w_rd_gnt   = w_idle && !flush_i && rd_valid_i && !w_wr_gnt;
    w_onehot   = NUM_WAYS'(1) << wr_way_i;
  end

  // SRAM pin drive for the cycle's winner; address/data are don't-care when idle.
  always_comb begin
    way_req_o  = '0;
    way_we_o   = '0;
    way_addr_o = rd_addr_i;
    way_data_o = wr_data_i;
    if (w_flushing) begin
      way_req_o  = '1;
      way_we_o   = '1;
      way_addr_o = r_cnt;
      way_data_o = '0;
    end else if (w_wr_gnt) begin
      way_req_o  = w_onehot;
      way_we_o   = w_onehot;
      way_addr_o = wr_addr_i;
    end else if (w_rd_gnt) begin
      way_req_o  = '1;
    end
  end

  assign rd_ready_o   = w_rd_gnt;
  assign wr_ready_o   = w_wr_gnt;
  assign flush_busy_o = (r_state == S_FLUSH);
  assign rd_rvalid_o  = r_rd_vld_p1;
  assign rd_data_o    = way_rdata_i;

  // State, sweep counter, starvation counter and the read-valid pipe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      // stage p0 -> p1: SRAM read data is valid one cycle after the grant
      r_rd_vld_p1 <= w_rd_gnt;
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end
          if (w_rd_gnt || !rd_valid_i) begin
            r_starve <= '0;
          end else if (w_wr_gnt && (r_starve != SC_W'(MAX_WR_BURST))) begin
            r_starve <= r_starve + SC_W'(1);
          end
        end
        default: begin
          if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_starve <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_way_sched.sv
// Directed bench for icache_way_sched with a behavioural 4-way SRAM model.
module tb_icache_way_sched;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, flush_busy_o;
  logic         rd_valid_i, rd_ready_o, rd_rvalid_o;
  logic [7:0]   rd_addr_i;
  logic [511:0] rd_data_o;
  logic         wr_valid_i, wr_ready_o;
  logic [7:0]   wr_addr_i;
  logic [1:0]   wr_way_i;
  logic [127:0] wr_data_i;
  logic [3:0]   way_req_o, way_we_o;
  logic [7:0]   way_addr_o;
  logic [127:0] way_data_o;
  logic [511:0] way_rdata_i;

  logic         bd_we;
  logic [7:0]   bd_addr;
  logic [127:0] mem [4][256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache_way_sched dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
    .rd_rvalid_o(rd_rvalid_o), .rd_data_o(rd_data_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_way_i(wr_way_i), .wr_data_i(wr_data_i),
    .way_req_o(way_req_o), .way_we_o(way_we_o), .way_addr_o(way_addr_o),
    .way_data_o(way_data_o), .way_rdata_i(way_rdata_i)
  );

  function automatic logic [127:0] init_val(input int w, input int a);
    return {8{w[7:0], a[7:0]}};
  endfunction

  function automatic logic [511:0] exp_all(input int a);
    return {init_val(3, a), init_val(2, a), init_val(1, a), init_val(0, a)};
  endfunction

  // SRAM model: 1-cycle registered read, write committed at the edge; the
  // backdoor port preloads a set of all ways with init_val.
  always @(posedge clk) begin
    if (bd_we)
      for (int w = 0; w < 4; w++) mem[w][bd_addr] <= init_val(w, int'(bd_addr));
    for (int w = 0; w < 4; w++) begin
      if (way_req_o[w]) begin
        if (way_we_o[w]) mem[w][way_addr_o] <= way_data_o;
        else             way_rdata_i[w*128 +: 128] <= mem[w][way_addr_o];
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rdv; logic [7:0] ra;
    logic wrv; logic [7:0] wa; logic [1:0] ww; logic [127:0] wd;
    logic e_rr; logic e_wr; logic [3:0] e_req; logic [3:0] e_we;
    logic e_rvld; logic chk_d; logic [511:0] e_d;
  } vec_t;

  function automatic vec_t mk(input logic rdv, input logic [7:0] ra, input logic wrv,
                              input logic [7:0] wa, input logic [1:0] ww, input logic [127:0] wd,
                              input logic e_rr, input logic e_wr, input logic [3:0] e_req,
                              input logic [3:0] e_we, input logic e_rvld, input logic chk_d,
                              input logic [511:0] e_d);
    vec_t v;
    v.rdv = rdv; v.ra = ra; v.wrv = wrv; v.wa = wa; v.ww = ww; v.wd = wd;
    v.e_rr = e_rr; v.e_wr = e_wr; v.e_req = e_req; v.e_we = e_we;
    v.e_rvld = e_rvld; v.chk_d = chk_d; v.e_d = e_d;
    return v;
  endfunction

  task automatic drive_idle();
    flush_i = 0; rd_valid_i = 0; wr_valid_i = 0;
    rd_addr_i = '0; wr_addr_i = '0; wr_way_i = '0; wr_data_i = '0;
  endtask

  vec_t tbl [19];

  initial begin
    logic [127:0] a5, d0, s77;
    a5  = {16{8'hA5}};
    d0  = {16{8'hD0}};
    s77 = {16{8'h77}};

    tbl[0] = mk(0, 8'h00, 0, 8'h00, 2'd0, '0, 0, 0, 4'h0, 4'h0, 0, 0, '0);
    tbl[1] = mk(0, 8'h00, 1, 8'h10, 2'd2, a5, 0, 1, 4'b0100, 4'b0100, 0, 0, '0);
    tbl[2] = mk(1, 8'h10, 0, 8'h00, 2'd0, '0, 1, 0, 4'hF, 4'h0, 0, 0, '0);
    tbl[3] = mk(0, 8'h00, 0, 8'h00, 2'd0, '0, 0, 0, 4'h0, 4'h0, 1, 1,
                {init_val(3, 16), a5, init_val(1, 16), init_val(0, 16)});
    for (int c = 1; c <= 12; c++) begin
      if (c == 5 || c == 10)
        tbl[3+c] = mk(1, 8'h30, 1, 8'h20, 2'd0, d0, 1, 0, 4'hF, 4'h0, 0, 0, '0);
      else
        tbl[3+c] = mk(1, 8'h30, 1, 8'h20, 2'd0, d0, 0, 1, 4'b0001, 4'b0001,
                      (c == 6 || c == 11), (c == 6 || c == 11), exp_all(8'h30));
    end
    tbl[16] = mk(0, 8'h00, 1, 8'h21, 2'd3, d0, 0, 1, 4'b1000, 4'b1000, 0, 0, '0);
    tbl[17] = mk(1, 8'h30, 1, 8'h22, 2'd3, d0, 0, 1, 4'b1000, 4'b1000, 0, 0, '0);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 2'd0, '0, 0, 0, 4'h0, 4'h0, 0, 0, '0);

    // Reset phase: preload all sets through the backdoor while requests are
    // offered, which must all be masked.
    rst_i = 1; drive_idle(); bd_we = 0; bd_addr = '0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bd_we = 1; bd_addr = 8'(a);
      rd_valid_i = 1; wr_valid_i = 1; rd_addr_i = 8'(a); wr_addr_i = 8'(a);
      #1;
      if (a == 5) begin
        chk("rst_rd_ready", 512'(rd_ready_o), 512'(0));
        chk("rst_wr_ready", 512'(wr_ready_o), 512'(0));
        chk("rst_req", 512'(way_req_o), 512'(0));
        chk("rst_we", 512'(way_we_o), 512'(0));
      end
    end
    @(negedge clk);
    rst_i = 0; bd_we = 0; drive_idle();
    #1;
    chk("reset_rvalid", 512'(rd_rvalid_o), 512'(0));
    chk("reset_busy", 512'(flush_busy_o), 512'(0));

    // Table-driven IDLE arbitration.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rd_valid_i = tbl[i].rdv; rd_addr_i = tbl[i].ra;
      wr_valid_i = tbl[i].wrv; wr_addr_i = tbl[i].wa;
      wr_way_i = tbl[i].ww; wr_data_i = tbl[i].wd;
      #1;
      chk($sformatf("t%0d_rd_ready", i), 512'(rd_ready_o), 512'(tbl[i].e_rr));
      chk($sformatf("t%0d_wr_ready", i), 512'(wr_ready_o), 512'(tbl[i].e_wr));
      chk($sformatf("t%0d_req", i), 512'(way_req_o), 512'(tbl[i].e_req));
      chk($sformatf("t%0d_we", i), 512'(way_we_o), 512'(tbl[i].e_we));
      chk($sformatf("t%0d_rvalid", i), 512'(rd_rvalid_o), 512'(tbl[i].e_rvld));
      if (tbl[i].e_req != 4'h0)
        chk($sformatf("t%0d_addr", i), 512'(way_addr_o),
            512'((tbl[i].e_we != 4'h0) ? tbl[i].wa : tbl[i].ra));
      if (tbl[i].e_we != 4'h0)
        chk($sformatf("t%0d_wdata", i), 512'(way_data_o), 512'(tbl[i].wd));
      if (tbl[i].chk_d)
        chk($sformatf("t%0d_rdata", i), rd_data_o, tbl[i].e_d);
    end

    // Eight back-to-back reads: continuous rvalid, data in address order.
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      drive_idle();
      rd_valid_i = (i < 8); rd_addr_i = 8'(i);
      #1;
      if (i < 8) chk($sformatf("b2b%0d_rd_ready", i), 512'(rd_ready_o), 512'(1));
      if (i > 0 && i <= 8) begin
        chk($sformatf("b2b%0d_rvalid", i), 512'(rd_rvalid_o), 512'(1));
        chk($sformatf("b2b%0d_rdata", i), rd_data_o, exp_all(i - 1));
      end
      if (i == 9) chk("b2b_rvalid_end", 512'(rd_rvalid_o), 512'(0));
    end

    // Flush together with pending read and write; mid-sweep flush pulse.
    @(negedge clk);
    flush_i = 1; rd_valid_i = 1; rd_addr_i = 8'hFF;
    wr_valid_i = 1; wr_addr_i = 8'h55; wr_way_i = 2'd1; wr_data_i = s77;
    #1;
    chk("fl_start_rd_ready", 512'(rd_ready_o), 512'(0));
    chk("fl_start_wr_ready", 512'(wr_ready_o), 512'(0));
    chk("fl_start_req", 512'(way_req_o), 512'(0));
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      flush_i = (i == 100);
      #1;
      chk($sformatf("fl%0d_busy", i), 512'(flush_busy_o), 512'(1));
      chk($sformatf("fl%0d_rd_ready", i), 512'(rd_ready_o), 512'(0));
      chk($sformatf("fl%0d_wr_ready", i), 512'(wr_ready_o), 512'(0));
      chk($sformatf("fl%0d_req", i), 512'(way_req_o), 512'(4'hF));
      chk($sformatf("fl%0d_we", i), 512'(way_we_o), 512'(4'hF));
      chk($sformatf("fl%0d_addr", i), 512'(way_addr_o), 512'(i));
      chk($sformatf("fl%0d_wdata", i), 512'(way_data_o), 512'(0));
    end
    @(negedge clk);
    flush_i = 0;
    #1;
    chk("fl_end_busy", 512'(flush_busy_o), 512'(0));
    chk("fl_end_wr_first", 512'(wr_ready_o), 512'(1));
    chk("fl_end_rd_wait", 512'(rd_ready_o), 512'(0));
    @(negedge clk);
    wr_valid_i = 0;
    #1;
    chk("fl_rd255_ready", 512'(rd_ready_o), 512'(1));
    @(negedge clk);
    rd_addr_i = 8'h00;
    #1;
    chk("fl_rd0_ready", 512'(rd_ready_o), 512'(1));
    chk("fl_set255_rvalid", 512'(rd_rvalid_o), 512'(1));
    chk("fl_set255_zero", rd_data_o, '0);
    @(negedge clk);
    rd_addr_i = 8'h55;
    #1;
    chk("fl_set0_zero", rd_data_o, '0);
    @(negedge clk);
    rd_valid_i = 0;
    #1;
    chk("fl_set55_refill", rd_data_o, {128'h0, 128'h0, s77, 128'h0});

    // Reset in the middle of a sweep.
    @(negedge clk);
    bd_we = 1; bd_addr = 8'd200;
    @(negedge clk);
    bd_we = 0; flush_i = 1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      flush_i = 0;
      if (i == 100) begin
        rst_i = 1; rd_valid_i = 1; rd_addr_i = 8'd200; wr_valid_i = 1;
      end
      #1;
      if (i == 99) chk("rs_busy_before", 512'(flush_busy_o), 512'(1));
    end
    chk("rs_rd_ready_in_rst", 512'(rd_ready_o), 512'(0));
    chk("rs_wr_ready_in_rst", 512'(wr_ready_o), 512'(0));
    chk("rs_req_in_rst", 512'(way_req_o), 512'(0));
    chk("rs_we_in_rst", 512'(way_we_o), 512'(0));
    @(negedge clk);
    #1;
    chk("rs_busy_after", 512'(flush_busy_o), 512'(0));
    chk("rs_rd_ready_after", 512'(rd_ready_o), 512'(0));
    chk("rs_req_after", 512'(way_req_o), 512'(0));
    chk("rs_no_rvalid", 512'(rd_rvalid_o), 512'(0));
    @(negedge clk);
    rst_i = 0; wr_valid_i = 0;
    #1;
    chk("rs_read_accepted", 512'(rd_ready_o), 512'(1));
    @(negedge clk);
    rd_valid_i = 0;
    #1;
    chk("rs_rvalid", 512'(rd_rvalid_o), 512'(1));
    chk("rs_set200_kept", rd_data_o, exp_all(200));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
